dmux4_queue16: RTL and testbench
================================

DMUX4_QUEUE16 -- requirements
Module: dmux4_queue16

Interface
REQ-001 SHALL have parameter DEPTH, default 2, entries per output queue (power of two, 2..8).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_data  input  16  word to route.
REQ-005 SHALL have port in_sel  input  2  destination: 0=a, 1=b, 2=c, 3=d.
REQ-006 SHALL have port in_valid  input  1  in_data/in_sel valid this cycle.
REQ-007 SHALL have port in_ready  output  1  queue addressed by in_sel can accept.
REQ-008 SHALL have ports out_a, out_b, out_c, out_d  output  16 each  head word of each queue.
REQ-009 SHALL have port out_valid  output  4  bit i: queue i non-empty (bit0=a .. bit3=d).
REQ-010 SHALL have port out_ready  input  4  bit i: consumer i takes head word this cycle.

Function
REQ-011 SHALL keep four independent FIFO queues of DEPTH x 16 bits, one per destination.
REQ-012 SHALL drive in_ready combinationally as NOT full of the queue selected by in_sel; no dependence on in_valid or out_ready.
REQ-013 SHALL push in_data into queue in_sel on a cycle where in_valid AND in_ready; otherwise no queue is written.
REQ-014 SHALL present a pushed word on its out_* port with out_valid bit set on the cycle after the push (latency 1, no same-cycle bypass).
REQ-015 SHALL pop queue i on a cycle where out_valid[i] AND out_ready[i]; out_ready[i] while empty is ignored.
REQ-016 SHALL preserve FIFO order per queue; queues are mutually independent, so pops on several queues in one cycle are allowed.
REQ-017 SHALL allow push and pop of the same non-full queue in one cycle: count unchanged, order preserved.
REQ-018 SHALL, when a queue is full, hold in_ready low for that destination even if the same queue pops that cycle (no pop-through).
REQ-019 SHALL track per-queue state EMPTY (count 0), PARTIAL (0<count<DEPTH), FULL (count=DEPTH); transitions only via push (+1) and pop (-1); push-only from FULL and pop-only from EMPTY are impossible or ignored.
REQ-020 SHALL use log2(DEPTH)-bit read/write pointers wrapping modulo DEPTH, and a count of log2(DEPTH)+1 bits.
REQ-021 SHALL drive out_x to 16'h0000 whenever the corresponding out_valid bit is 0.
REQ-022 SHALL hold out_x stable while out_valid is set and no pop occurs.

Reset
REQ-023 SHALL, on clk edge with reset=1, clear all counts and pointers, set all queues EMPTY, out_valid=4'b0000, out_a..out_d=0.
REQ-024 SHALL discard queue contents on reset mid-operation; a push presented in the reset cycle is dropped.
REQ-025 SHALL drive in_ready=1 in the cycle after reset is released (all queues empty).

Structure
REQ-026 SHALL place DATA_W=16, NUM_CH=4, SEL_W=2 and the queue-state encoding (EMPTY/PARTIAL/FULL) in a shared package/include.
REQ-027 SHALL instantiate one sub-module, queue16 (single DEPTH x 16 FIFO with push/pop/full/empty/head), four times; routing logic lives in the top.

Verification
REQ-028 After reset, push 16'h1234 sel=2 -> next cycle out_valid=4'b0100, out_c=16'h1234, others 0.
REQ-029 DEPTH=2: push 16'hA001, 16'hA002, 16'hA003 to sel=0 with out_ready=0 -> in_ready low on third; queue a holds A001,A002; after two pops A003 accepted.
REQ-030 Queue b count 1 (16'h0B01): push 16'h0B02 sel=1 while out_ready[1]=1 -> out_b=16'h0B02 next cycle, count stays 1.
REQ-031 Queues a..d each hold one word, out_ready=4'b1111 for one cycle -> out_valid=4'b0000 next cycle, all out_* = 0.
REQ-032 Queues holding data, assert reset for one cycle together with a valid push -> out_valid=0, outputs 0, pushed word never appears.
REQ-033 Queue d full, in_sel toggles 3->0 with in_valid=1 -> in_ready 0 then 1; word accepted into queue a only.

Source files
------------

// File: rtl/dmux4_queue16_pkg.sv
// Shared widths and per-queue occupancy encoding for the four-way routing queue.
package dmux4_queue16_pkg;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic [1:0] {
        Q_EMPTY   = 2'd0,
        Q_PARTIAL = 2'd1,
        Q_FULL    = 2'd2
    } qstate_t;
endpackage

// File: rtl/dmux4_queue16_queue16.sv
// Single DEPTH x DATA_W FIFO with an explicit EMPTY/PARTIAL/FULL occupancy state.
module queue16
    import dmux4_queue16_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_head,
    output logic              o_full,
    output logic              o_empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_count;
    qstate_t           r_state;

    logic              w_push;
    logic              w_pop;
    logic [AW:0]       w_count_nxt;
    qstate_t           w_state_nxt;

    // Push is refused on FULL even when a pop happens the same cycle.
    assign w_push = i_push && (r_state != Q_FULL);
    assign w_pop  = i_pop  && (r_state != Q_EMPTY);

    always_comb begin
        w_count_nxt = r_count;
        w_state_nxt = r_state;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_ONE;
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - CNT_ONE;
        end
        if (w_count_nxt == '0) begin
            w_state_nxt = Q_EMPTY;
        end else if (w_count_nxt == CNT_DEPTH) begin
            w_state_nxt = Q_FULL;
        end else begin
            w_state_nxt = Q_PARTIAL;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= Q_EMPTY;
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    assign o_full  = (r_state == Q_FULL);
    assign o_empty = (r_state == Q_EMPTY);
    assign o_head  = o_empty ? '0 : r_mem[r_rptr];
endmodule

// File: rtl/dmux4_queue16.sv
// Routes each input word to one of four independent output FIFOs selected by in_sel.
module dmux4_queue16
    import dmux4_queue16_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [DATA_W-1:0] out_c,
    output logic [DATA_W-1:0] out_d,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready
);
    logic [NUM_CH-1:0] w_full;
    logic [NUM_CH-1:0] w_empty;
    logic [NUM_CH-1:0] w_push;
    logic [NUM_CH-1:0] w_pop;
    logic [DATA_W-1:0] w_head [NUM_CH];

    assign in_ready  = ~w_full[in_sel];
    assign out_valid = ~w_empty;
    assign w_pop     = out_valid & out_ready;

    always_comb begin
        w_push = '0;
        if (in_valid && in_ready) begin
            w_push[in_sel] = 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_queue
        queue16 #(
            .DEPTH(DEPTH)
        ) u_queue (
            .clk    (clk),
            .reset  (reset),
            .i_push (w_push[g]),
            .i_pop  (w_pop[g]),
            .i_data (in_data),
            .o_head (w_head[g]),
            .o_full (w_full[g]),
            .o_empty(w_empty[g])
        );
    end

    assign out_a = w_head[0];
    assign out_b = w_head[1];
    assign out_c = w_head[2];
    assign out_d = w_head[3];
endmodule

// File: tb/tb_dmux4_queue16.sv
// Scoreboard bench for dmux4_queue16: per-queue model FIFOs checked against outputs.
module tb_dmux4_queue16;
    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] in_data = '0;
    logic [1:0]  in_sel = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] out_a, out_b, out_c, out_d;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready = '0;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [15:0] mq [4][$];

    dmux4_queue16 #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_a    (out_a),
        .out_b    (out_b),
        .out_c    (out_c),
        .out_d    (out_d),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] dut_out(input int unsigned ch);
        case (ch)
            0: dut_out = out_a;
            1: dut_out = out_b;
            2: dut_out = out_c;
            default: dut_out = out_d;
        endcase
    endfunction

    function automatic logic [15:0] exp_out(input int unsigned ch);
        exp_out = (mq[ch].size() > 0) ? mq[ch][0] : 16'h0000;
    endfunction

    function automatic logic [3:0] exp_valid();
        exp_valid = '0;
        for (int unsigned c = 0; c < 4; c++) exp_valid[c] = (mq[c].size() > 0);
    endfunction

    // One cycle: drive at negedge, sample in_ready, update the model at posedge, return at negedge.
    task automatic tick(input logic rst, input logic v, input logic [1:0] sel,
                        input logic [15:0] d, input logic [3:0] rdy,
                        output logic obs_rdy, output logic exp_rdy);
        reset = rst; in_valid = v; in_sel = sel; in_data = d; out_ready = rdy;
        #1;
        obs_rdy = in_ready;
        exp_rdy = (mq[sel].size() < DEPTH);
        @(posedge clk);
        if (rst) begin
            for (int unsigned c = 0; c < 4; c++) mq[c].delete();
        end else begin
            for (int unsigned c = 0; c < 4; c++)
                if (rdy[c] && mq[c].size() > 0) void'(mq[c].pop_front());
            if (v && exp_rdy) mq[sel].push_back(d);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic o, e;
        tick(1'b1, 1'b0, 2'd0, 16'h0, 4'h0, o, e);
        n_vec++;
        if (out_valid !== 4'b0000) begin
            n_err++; $display("FAIL reset_valid: got %b, required 0000", out_valid);
        end
        for (int unsigned c = 0; c < 4; c++) begin
            n_vec++;
            if (dut_out(c) !== 16'h0000) begin
                n_err++; $display("FAIL reset_out%0d: got %h, required 0000", c, dut_out(c));
            end
        end
        for (int unsigned s = 0; s < 4; s++) begin
            tick(1'b0, 1'b0, 2'(s), 16'h0, 4'h0, o, e);
            n_vec++;
            if (o !== 1'b1) begin
                n_err++; $display("FAIL reset_ready_sel%0d: got %b, required 1", s, o);
            end
        end
    endtask

    task automatic test_single();
        logic o, e;
        tick(1'b0, 1'b1, 2'd2, 16'h1234, 4'h0, o, e);
        n_vec++;
        if (out_valid !== 4'b0100 || out_c !== 16'h1234) begin
            n_err++; $display("FAIL single_c: got valid=%b c=%h, required 0100/1234", out_valid, out_c);
        end
        n_vec++;
        if ({out_a, out_b, out_d} !== 48'h0) begin
            n_err++; $display("FAIL single_others: got a=%h b=%h d=%h, required 0", out_a, out_b, out_d);
        end
        tick(1'b0, 1'b0, 2'd0, 16'h0, 4'b0100, o, e);
        n_vec++;
        if (out_valid !== exp_valid() || out_c !== 16'h0000) begin
            n_err++; $display("FAIL single_pop: got valid=%b c=%h, required %b/0000", out_valid, out_c, exp_valid());
        end
    endtask

    task automatic test_full();
        logic o, e;
        logic [15:0] w [3];
        w[0] = 16'hA001; w[1] = 16'hA002; w[2] = 16'hA003;
        for (int unsigned k = 0; k < 3; k++) begin
            tick(1'b0, 1'b1, 2'd0, w[k], 4'h0, o, e);
            n_vec++;
            if (o !== (k < 2) || o !== e) begin
                n_err++; $display("FAIL full_ready%0d: got %b, required %b", k, o, (k < 2));
            end
        end
        for (int unsigned k = 0; k < 2; k++) begin
            n_vec++;
            if (out_a !== w[k] || out_a !== exp_out(0)) begin
                n_err++; $display("FAIL full_head%0d: got %h, required %h", k, out_a, w[k]);
            end
            tick(1'b0, 1'b0, 2'd0, 16'h0, 4'b0001, o, e);
        end
        n_vec++;
        if (out_valid[0] !== 1'b0) begin
            n_err++; $display("FAIL full_drained: got %b, required 0", out_valid[0]);
        end
        tick(1'b0, 1'b1, 2'd0, w[2], 4'h0, o, e);
        n_vec++;
        if (o !== 1'b1 || out_a !== 16'hA003) begin
            n_err++; $display("FAIL full_refill: got ready=%b a=%h, required 1/a003", o, out_a);
        end
        tick(1'b0, 1'b0, 2'd0, 16'h0, 4'b0001, o, e);
    endtask

    task automatic test_push_pop();
        logic o, e;
        tick(1'b0, 1'b1, 2'd1, 16'h0B01, 4'h0, o, e);
        tick(1'b0, 1'b1, 2'd1, 16'h0B02, 4'b0010, o, e);
        n_vec++;
        if (o !== 1'b1 || out_b !== 16'h0B02 || out_valid !== 4'b0010) begin
            n_err++; $display("FAIL pushpop_b: got ready=%b b=%h valid=%b, required 1/0b02/0010", o, out_b, out_valid);
        end
        tick(1'b0, 1'b0, 2'd1, 16'h0, 4'b0010, o, e);
        n_vec++;
        if (out_valid[1] !== 1'b0 || out_b !== 16'h0000) begin
            n_err++; $display("FAIL pushpop_count: got valid=%b b=%h, required 0/0000", out_valid[1], out_b);
        end
    endtask

    task automatic test_multi_pop();
        logic o, e;
        for (int unsigned c = 0; c < 4; c++)
            tick(1'b0, 1'b1, 2'(c), 16'hC000 + 16'(c), 4'h0, o, e);
        n_vec++;
        if (out_valid !== 4'b1111 || out_d !== 16'hC003 || out_a !== 16'hC000) begin
            n_err++; $display("FAIL multi_fill: got valid=%b a=%h d=%h, required 1111/c000/c003", out_valid, out_a, out_d);
        end
        tick(1'b0, 1'b0, 2'd0, 16'h0, 4'b1111, o, e);
        n_vec++;
        if (out_valid !== 4'b0000 || {out_a, out_b, out_c, out_d} !== 64'h0) begin
            n_err++; $display("FAIL multi_pop: got valid=%b outs=%h%h%h%h, required 0", out_valid, out_a, out_b, out_c, out_d);
        end
    endtask

    task automatic test_reset_mid();
        logic o, e;
        tick(1'b0, 1'b1, 2'd0, 16'h5A01, 4'h0, o, e);
        tick(1'b0, 1'b1, 2'd3, 16'h5A02, 4'h0, o, e);
        tick(1'b1, 1'b1, 2'd1, 16'hDEAD, 4'h0, o, e);
        n_vec++;
        if (out_valid !== 4'b0000 || {out_a, out_b, out_c, out_d} !== 64'h0) begin
            n_err++; $display("FAIL rstmid_clear: got valid=%b outs=%h%h%h%h, required 0", out_valid, out_a, out_b, out_c, out_d);
        end
        tick(1'b0, 1'b0, 2'd1, 16'h0, 4'h0, o, e);
        n_vec++;
        if (out_valid !== 4'b0000 || out_b !== 16'h0000 || o !== 1'b1) begin
            n_err++; $display("FAIL rstmid_drop: got valid=%b b=%h ready=%b, required 0000/0000/1", out_valid, out_b, o);
        end
    endtask

    task automatic test_full_toggle();
        logic o, e;
        tick(1'b0, 1'b1, 2'd3, 16'hD001, 4'h0, o, e);
        tick(1'b0, 1'b1, 2'd3, 16'hD002, 4'h0, o, e);
        tick(1'b0, 1'b1, 2'd3, 16'hD003, 4'b1000, o, e);
        n_vec++;
        if (o !== 1'b0 || out_d !== 16'hD002) begin
            n_err++; $display("FAIL toggle_nopopthru: got ready=%b d=%h, required 0/d002", o, out_d);
        end
        tick(1'b0, 1'b1, 2'd3, 16'hD004, 4'h0, o, e);
        tick(1'b0, 1'b1, 2'd0, 16'hA0A0, 4'h0, o, e);
        n_vec++;
        if (o !== 1'b1 || out_valid !== 4'b1001 || out_a !== 16'hA0A0 || out_d !== 16'hD002) begin
            n_err++; $display("FAIL toggle_accept: got ready=%b valid=%b a=%h d=%h, required 1/1001/a0a0/d002", o, out_valid, out_a, out_d);
        end
        tick(1'b0, 1'b0, 2'd0, 16'h0, 4'b1001, o, e);
        n_vec++;
        if (out_valid !== 4'b1000 || out_d !== 16'hD004) begin
            n_err++; $display("FAIL toggle_order: got valid=%b d=%h, required 1000/d004", out_valid, out_d);
        end
        tick(1'b0, 1'b0, 2'd0, 16'h0, 4'b1000, o, e);
    endtask

    task automatic test_random();
        logic o, e;
        logic [3:0] rdy;
        for (int unsigned n = 0; n < 400; n++) begin
            rdy = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            for (int unsigned c = 0; c < 4; c++) begin
                n_vec++;
                if (out_valid[c] !== exp_valid()[c] || dut_out(c) !== exp_out(c)) begin
                    n_err++; $display("FAIL rand_q%0d cyc%0d: got v=%b d=%h, required v=%b d=%h",
                                      c, n, out_valid[c], dut_out(c), exp_valid()[c], exp_out(c));
                end
            end
            tick(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 16'($urandom), rdy, o, e);
            n_vec++;
            if (o !== e) begin
                n_err++; $display("FAIL rand_ready cyc%0d: got %b, required %b", n, o, e);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_full();
        test_push_pop();
        test_multi_pop();
        test_reset_mid();
        test_full_toggle();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
